// File: rtl/vend_event_arbiter.sv
// Serializes single-cycle key events into one valid/ready event stream under
// fixed priority, with a per-source pending latch and a post-accept hold-off gap.
module vend_event_arbiter #(
    parameter int NUM_OF_PRODUCTS = 5,
    parameter int MONEY_BUTTONS   = 3,
    parameter int HOLDOFF_CYCLES  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_OF_PRODUCTS-1:0] product_pulse,
    input  logic [MONEY_BUTTONS-1:0]   money_pulse,
    input  logic                       tran_cancel_pulse,
    input  logic                       product_refill_pulse,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [1:0]                 evt_type,
    output logic [3:0]                 evt_index,
    output logic                       pend_overflow,
    output logic                       busy
);

    // Pending bit order is also priority order: lowest bit wins.
    localparam int R = NUM_OF_PRODUCTS + MONEY_BUTTONS + 2;
    localparam logic [7:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? 8'(HOLDOFF_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [R-1:0] pend;
    logic [R-1:0] pend_nxt;
    logic [R-1:0] req;
    logic [R-1:0] clr;
    logic [7:0]   hold_cnt;
    logic [1:0]   type_q;
    logic [3:0]   index_q;
    logic         take;
    int           sel;
    logic [1:0]   sel_type;
    logic [3:0]   sel_index;

    function automatic int pri_sel(input logic [R-1:0] p);
        int s;
        s = 0;
        for (int i = R - 1; i >= 0; i--) begin
            if (p[i]) s = i;
        end
        return s;
    endfunction

    assign req  = {product_pulse, money_pulse, product_refill_pulse, tran_cancel_pulse};
    assign take = (state == IDLE) && (|pend);
    assign sel  = pri_sel(pend);

    always_comb begin
        sel_type  = 2'd0;
        sel_index = 4'd0;
        if (sel == 0) begin
            sel_type = 2'd2;
        end else if (sel == 1) begin
            sel_type = 2'd3;
        end else if (sel < MONEY_BUTTONS + 2) begin
            sel_type  = 2'd0;
            sel_index = 4'(sel - 2);
        end else begin
            sel_type  = 2'd1;
            sel_index = 4'(sel - 2 - MONEY_BUTTONS);
        end
    end

    // A new pulse on the source being latched this cycle re-arms it (set wins).
    always_comb begin
        clr = '0;
        for (int i = 0; i < R; i++) begin
            clr[i] = take && (sel == i);
        end
        pend_nxt = (pend & ~clr) | req;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = OFFER;
            OFFER:   if (evt_ready) state_nxt = (HOLDOFF_CYCLES > 0) ? HOLD : IDLE;
            HOLD:    if (hold_cnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        evt_valid = (state == OFFER);
        evt_type  = type_q;
        evt_index = index_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend          <= '0;
            hold_cnt      <= 8'd0;
            type_q        <= 2'd0;
            index_q       <= 4'd0;
            pend_overflow <= 1'b0;
            busy          <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (take) begin
                type_q  <= sel_type;
                index_q <= sel_index;
            end
            if (state == OFFER && evt_ready) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
            pend_overflow <= |(req & pend & ~clr);
            busy          <= (state_nxt != IDLE) || (|pend_nxt);
        end
    end

endmodule

// File: tb/tb_vend_event_arbiter.sv
// Directed and randomized bench for vend_event_arbiter against a timestamp-based
// reference model of the arbitration rules.
module tb_vend_event_arbiter;

    localparam int N = 5;
    localparam int M = 3;
    localparam int H = 4;
    localparam int R = N + M + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] product_pulse;
    logic [M-1:0] money_pulse;
    logic         tran_cancel_pulse;
    logic         product_refill_pulse;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_type;
    logic [3:0]   evt_index;
    logic         pend_overflow;
    logic         busy;

    vend_event_arbiter #(
        .NUM_OF_PRODUCTS(N),
        .MONEY_BUTTONS  (M),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .product_pulse       (product_pulse),
        .money_pulse         (money_pulse),
        .tran_cancel_pulse   (tran_cancel_pulse),
        .product_refill_pulse(product_refill_pulse),
        .evt_valid           (evt_valid),
        .evt_ready           (evt_ready),
        .evt_type            (evt_type),
        .evt_index           (evt_index),
        .pend_overflow       (pend_overflow),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: sources numbered in priority order (0 cancel, 1 refill,
    // 2.. money, then products); issue permitted from edge m_next onward.
    bit m_pend[R];
    bit m_valid;
    int m_src;
    int m_next;
    bit m_ovf;
    bit m_busy;

    int hs_cnt[R];
    int hs_total = 0;
    int ovf_cnt  = 0;
    int hs_q[$];
    int hs_t[$];

    function automatic int exp_type(input int s);
        if (s == 0) return 2;
        if (s == 1) return 3;
        if (s < 2 + M) return 0;
        return 1;
    endfunction

    function automatic int exp_index(input int s);
        if (s < 2) return 0;
        if (s < 2 + M) return s - 2;
        return s - 2 - M;
    endfunction

    function automatic int src_of(input logic [1:0] t, input logic [3:0] idx);
        int s;
        case (t)
            2'd2:    s = 0;
            2'd3:    s = 1;
            2'd0:    s = 2 + int'(idx);
            default: s = 2 + M + int'(idx);
        endcase
        if (s < 0 || s >= R) s = 0;
        return s;
    endfunction

    function automatic bit pulse_of(input int i);
        if (i == 0) return tran_cancel_pulse;
        if (i == 1) return product_refill_pulse;
        if (i < 2 + M) return money_pulse[i-2];
        return product_pulse[i-2-M];
    endfunction

    task automatic model_edge();
        int  clr;
        bit  ovf;
        bit  any;
        bit  p;
        if (rst) begin
            for (int i = 0; i < R; i++) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_src   = 0;
            m_next  = 0;
            m_ovf   = 1'b0;
            m_busy  = 1'b0;
        end else begin
            clr = -1;
            if (m_valid) begin
                if (evt_ready) begin
                    m_valid = 1'b0;
                    m_next  = cyc + H + 1;
                end
            end else if (cyc >= m_next) begin
                for (int i = R - 1; i >= 0; i--) begin
                    if (m_pend[i]) clr = i;
                end
                if (clr >= 0) begin
                    m_valid = 1'b1;
                    m_src   = clr;
                end
            end
            ovf = 1'b0;
            any = 1'b0;
            for (int i = 0; i < R; i++) begin
                p = pulse_of(i);
                if (p && m_pend[i] && i != clr) ovf = 1'b1;
                m_pend[i] = (m_pend[i] && i != clr) || p;
                if (m_pend[i]) any = 1'b1;
            end
            m_ovf  = ovf;
            m_busy = m_valid || (cyc < m_next - 1) || any;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) begin
            chk("type", 32'(evt_type), 32'(exp_type(m_src)));
            chk("index", 32'(evt_index), 32'(exp_index(m_src)));
        end
        chk("overflow", 32'(pend_overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic clear_pulses();
        product_pulse        = '0;
        money_pulse          = '0;
        tran_cancel_pulse    = 1'b0;
        product_refill_pulse = 1'b0;
    endtask

    task automatic step();
        bit hs;
        int s;
        hs = (evt_valid === 1'b1) && (evt_ready === 1'b1) && (rst === 1'b0);
        s  = src_of(evt_type, evt_index);
        @(posedge clk);
        cyc++;
        model_edge();
        if (hs) begin
            hs_cnt[s]++;
            hs_total++;
            hs_q.push_back(s);
            hs_t.push_back(cyc);
        end
        #1;
        if (pend_overflow === 1'b1) ovf_cnt++;
        check_model();
        clear_pulses();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int ovf0;
        int cnt0;
        int cnt1;
        int tot0;

        for (int i = 0; i < R; i++) begin
            m_pend[i] = 1'b0;
            hs_cnt[i] = 0;
        end
        m_valid = 1'b0; m_src = 0; m_next = 0; m_ovf = 1'b0; m_busy = 1'b0;
        clear_pulses();
        evt_ready = 1'b0;
        rst       = 1'b1;

        // Reset state
        step();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_type", 32'(evt_type), 32'd0);
        chk("rst_index", 32'(evt_index), 32'd0);
        chk("rst_ovf", 32'(pend_overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        run(2);

        // Single money event
        evt_ready   = 1'b1;
        ovf0        = ovf_cnt;
        money_pulse = 3'b010;
        step();
        chk("single_pending_valid", 32'(evt_valid), 32'd0);
        step();
        chk("single_valid", 32'(evt_valid), 32'd1);
        chk("single_type", 32'(evt_type), 32'd0);
        chk("single_index", 32'(evt_index), 32'd1);
        step();
        chk("single_drop", 32'(evt_valid), 32'd0);
        run(6);
        chk("single_busy_end", 32'(busy), 32'd0);
        chk("single_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);

        // Simultaneous pulses drain in priority order
        hs_q.delete();
        hs_t.delete();
        product_pulse     = 5'b01000;
        money_pulse       = 3'b001;
        tran_cancel_pulse = 1'b1;
        run(22);
        chk("simul_count", 32'(hs_q.size()), 32'd3);
        if (hs_q.size() == 3) begin
            chk("simul_first", 32'(hs_q[0]), 32'd0);
            chk("simul_second", 32'(hs_q[1]), 32'd2);
            chk("simul_third", 32'(hs_q[2]), 32'(2 + M + 3));
            chk("simul_gap1", 32'(hs_t[1] - hs_t[0]), 32'(H + 2));
            chk("simul_gap2", 32'(hs_t[2] - hs_t[1]), 32'(H + 2));
        end

        // Backpressure with refill pulses arriving during the stall
        evt_ready     = 1'b0;
        cnt0          = hs_cnt[2 + M + 2];
        cnt1          = hs_cnt[1];
        product_pulse = 5'b00100;
        run(2);
        for (int i = 0; i < 20; i++) begin
            if (i == 4 || i == 11) product_refill_pulse = 1'b1;
            step();
            chk("bp_valid", 32'(evt_valid), 32'd1);
            chk("bp_type", 32'(evt_type), 32'd1);
            chk("bp_index", 32'(evt_index), 32'd2);
        end
        evt_ready = 1'b1;
        run(16);
        chk("bp_product_once", 32'(hs_cnt[2 + M + 2] - cnt0), 32'd1);
        chk("bp_refill_once", 32'(hs_cnt[1] - cnt1), 32'd1);

        // Overflow on money[2] while stalled on product[1]
        evt_ready     = 1'b0;
        ovf0          = ovf_cnt;
        cnt0          = hs_cnt[2 + 2];
        product_pulse = 5'b00010;
        run(2);
        money_pulse = 3'b100;
        step();
        run(2);
        money_pulse = 3'b100;
        step();
        run(3);
        evt_ready = 1'b1;
        run(20);
        chk("ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
        chk("ovf_money2_once", 32'(hs_cnt[2 + 2] - cnt0), 32'd1);

        // Set wins over the same-cycle latch clear
        ovf0          = ovf_cnt;
        cnt0          = hs_cnt[2 + M];
        product_pulse = 5'b00001;
        step();
        product_pulse = 5'b00001;
        step();
        run(20);
        chk("setwin_twice", 32'(hs_cnt[2 + M] - cnt0), 32'd2);
        chk("setwin_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);

        // Reset while offering with several sources pending
        evt_ready     = 1'b0;
        product_pulse = 5'b10000;
        run(2);
        money_pulse          = 3'b011;
        product_refill_pulse = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_valid", 32'(evt_valid), 32'd0);
        chk("rstmid_type", 32'(evt_type), 32'd0);
        chk("rstmid_index", 32'(evt_index), 32'd0);
        chk("rstmid_ovf", 32'(pend_overflow), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        evt_ready = 1'b1;
        tot0      = hs_total;
        run(12);
        chk("rstmid_no_events", 32'(hs_total - tot0), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int j = 0; j < N; j++) product_pulse[j] = ($urandom_range(0, 13) == 0);
            for (int j = 0; j < M; j++) money_pulse[j] = ($urandom_range(0, 11) == 0);
            tran_cancel_pulse    = ($urandom_range(0, 19) == 0);
            product_refill_pulse = ($urandom_range(0, 23) == 0);
            evt_ready            = ($urandom_range(0, 3) != 0);
            rst                  = ($urandom_range(0, 249) == 0);
            step();
            rst = 1'b0;
        end
        evt_ready = 1'b1;
        run(60);
        chk("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
